// File: rtl/rs232_uart_if.sv
// Word-level handshake between a UART and its host: transmit request/ready
// and the receive strobe with its data and error flags.
interface rs232_uart_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/rs232_uart.sv
// Full-duplex RS232 UART: independent receive and transmit FSMs sharing only
// clock and reset. Bit timing comes from up-counters that wrap at
// CLKS_PER_BIT-1; the receiver centres its samples on the start-bit midpoint.
//
//   state    | meaning
//   R_IDLE   | waiting for a synchronized falling edge on the rx line
//   R_START  | half a bit into the start bit, confirm it is still low
//   R_DATA   | sampling data bits LSB first, one per bit period
//   R_PARITY | sampling the parity bit (never entered when PARITY=0)
//   R_STOP   | sampling the first stop bit, then strobe rx_valid
//   T_IDLE   | tx_ready high, line idle high
//   T_START  | driving the start bit
//   T_DATA   | shifting data bits out LSB first
//   T_PARITY | driving the parity bit (never entered when PARITY=0)
//   T_STOP   | driving STOP_BITS high bits
module rs232_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rx,
  output logic          o_tx,
  rs232_uart_if.slave   if_uart
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam bit PAR_EN  = (PARITY != 0);
  localparam bit PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

  rx_state_t            r_rx_state, w_rx_next;
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CW-1:0]        r_rx_cnt;
  logic [BW-1:0]        r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 w_rx, w_rx_fall, w_rx_tick, w_rx_half, w_rx_done;

  tx_state_t            r_tx_state, w_tx_next;
  logic [CW-1:0]        r_tx_cnt;
  logic [BW-1:0]        r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 w_tx_tick;

  assign w_rx      = r_rx_s2;
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_tick = (r_rx_cnt == CNT_LAST);
  assign w_rx_half = (r_rx_cnt == CNT_HALF);
  assign w_tx_tick = (r_tx_cnt == CNT_LAST);

  // rx synchronizer plus one history flop for edge detection; reset high so a
  // fresh falling edge is needed after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // receive state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= R_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // receive next-state; finishing the stop sample returns straight to idle
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_done = 1'b0;
    case (r_rx_state)
      R_IDLE:   if (w_rx_fall) w_rx_next = R_START;
      R_START:  if (w_rx_half) w_rx_next = w_rx ? R_IDLE : R_DATA;
      R_DATA:   if (w_rx_tick && r_rx_bit == BIT_LAST) w_rx_next = PAR_EN ? R_PARITY : R_STOP;
      R_PARITY: if (w_rx_tick) w_rx_next = R_STOP;
      R_STOP: begin
        if (w_rx_tick) begin
          w_rx_next = R_IDLE;
          w_rx_done = 1'b1;
        end
      end
      default:  w_rx_next = R_IDLE;
    endcase
  end

  // receive bit timing, shift register and delivered-word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt              <= '0;
      r_rx_bit              <= '0;
      r_rx_shift            <= '0;
      r_rx_par              <= 1'b0;
      if_uart.rx_valid      <= 1'b0;
      if_uart.rx_data       <= '0;
      if_uart.rx_frame_err  <= 1'b0;
      if_uart.rx_parity_err <= 1'b0;
    end else begin
      if_uart.rx_valid <= w_rx_done;
      if (r_rx_state == R_IDLE || (r_rx_state == R_START && w_rx_half) || w_rx_tick)
        r_rx_cnt <= '0;
      else
        r_rx_cnt <= r_rx_cnt + CW'(1);
      if (r_rx_state == R_START) r_rx_bit <= '0;
      if (r_rx_state == R_DATA && w_rx_tick) begin
        r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
        r_rx_bit   <= r_rx_bit + BW'(1);
      end
      if (r_rx_state == R_PARITY && w_rx_tick) r_rx_par <= w_rx;
      if (w_rx_done) begin
        if_uart.rx_data       <= r_rx_shift;
        if_uart.rx_frame_err  <= ~w_rx;
        if_uart.rx_parity_err <= PAR_EN & (^r_rx_shift ^ r_rx_par ^ PAR_ODD);
      end
    end
  end

  // transmit state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= T_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  // transmit next-state
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      T_IDLE:   if (if_uart.tx_valid) w_tx_next = T_START;
      T_START:  if (w_tx_tick) w_tx_next = T_DATA;
      T_DATA:   if (w_tx_tick && r_tx_bit == BIT_LAST) w_tx_next = PAR_EN ? T_PARITY : T_STOP;
      T_PARITY: if (w_tx_tick) w_tx_next = T_STOP;
      T_STOP:   if (w_tx_tick && r_tx_bit == STOP_LAST) w_tx_next = T_IDLE;
      default:  w_tx_next = T_IDLE;
    endcase
  end

  // transmit line level decoded from state so reset forces it high at once
  always_comb begin
    o_tx = 1'b1;
    case (r_tx_state)
      T_START:  o_tx = 1'b0;
      T_DATA:   o_tx = r_tx_shift[0];
      T_PARITY: o_tx = r_tx_par;
      default:  o_tx = 1'b1;
    endcase
  end

  assign if_uart.tx_ready = (r_tx_state == T_IDLE);

  // transmit bit timing; word and parity captured at acceptance only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      if (r_tx_state == T_IDLE || w_tx_tick) r_tx_cnt <= '0;
      else                                   r_tx_cnt <= r_tx_cnt + CW'(1);
      if (r_tx_state == T_IDLE && if_uart.tx_valid) begin
        r_tx_shift <= if_uart.tx_data;
        r_tx_par   <= ^if_uart.tx_data ^ PAR_ODD;
        r_tx_bit   <= '0;
      end
      if (r_tx_state == T_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= (r_tx_bit == BIT_LAST) ? '0 : r_tx_bit + BW'(1);
      end
      if (r_tx_state == T_STOP && w_tx_tick) r_tx_bit <= r_tx_bit + BW'(1);
    end
  end
endmodule
